// File: rtl/rover_pkg.sv
// Shared rover tracker types and constants.
// State encodings, location field widths, no-echo sentinels, clock rate.
package rover_pkg;

    localparam int CLK_HZ  = 27000000;
    localparam int ANGLE_W = 4;
    localparam int DIST_W  = 8;
    localparam int LOC_W   = ANGLE_W + DIST_W;

    localparam logic [DIST_W-1:0] NO_ECHO_LO = 8'h00;
    localparam logic [DIST_W-1:0] NO_ECHO_HI = 8'hFF;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_WAIT    = 3'd2,
        S_FILTER  = 3'd3,
        S_PUBLISH = 3'd4,
        S_RECOVER = 3'd5
    } state_t;

    function automatic logic is_no_echo(input logic [DIST_W-1:0] d);
        return (d == NO_ECHO_LO) || (d == NO_ECHO_HI);
    endfunction

endpackage

// File: rtl/ultrasound_scan_scheduler_if.sv
// Bundle between the scan scheduler, the main FSM and the calculator.
// slave: scheduler side; master: main FSM / calculator / bench side.
interface ultrasound_scan_scheduler_if;
    import rover_pkg::*;

    logic             enable;
    logic             request;
    logic             calc_done;
    logic [LOC_W-1:0] calc_location;
    logic             calculate;
    logic             calc_reset;
    logic [LOC_W-1:0] location;
    logic             location_valid;
    logic             no_echo;
    logic             busy;
    logic [7:0]       timeout_count;
    logic [2:0]       state;

    modport slave (
        input  enable, request, calc_done, calc_location,
        output calculate, calc_reset, location, location_valid,
        output no_echo, busy, timeout_count, state
    );

    modport master (
        output enable, request, calc_done, calc_location,
        input  calculate, calc_reset, location, location_valid,
        input  no_echo, busy, timeout_count, state
    );

endinterface

// File: rtl/median3_filter.sv
// Three-entry distance history with fill count and median output.
// Ports: clock, clear_i (sync clear), push_i, din_i, med_o (combinational).
module median3_filter
    import rover_pkg::*;
(
    input  logic              clock,
    input  logic              clear_i,
    input  logic              push_i,
    input  logic [DIST_W-1:0] din_i,
    output logic [DIST_W-1:0] med_o
);

    logic [DIST_W-1:0] h0_q, h1_q, h2_q;
    logic [1:0]        fill_q;
    logic [DIST_W-1:0] lo_ab, hi_ab, lo_c, med3;

    always_ff @(posedge clock) begin
        if (clear_i) begin
            h0_q   <= '0;
            h1_q   <= '0;
            h2_q   <= '0;
            fill_q <= 2'd0;
        end else if (push_i) begin
            h0_q <= din_i;
            h1_q <= h0_q;
            h2_q <= h1_q;
            if (fill_q != 2'd3)
                fill_q <= fill_q + 2'd1;
        end
    end

    // median = max(min(a,b), min(max(a,b),c))
    always_comb begin
        lo_ab = (h0_q < h1_q) ? h0_q : h1_q;
        hi_ab = (h0_q < h1_q) ? h1_q : h0_q;
        lo_c  = (hi_ab < h2_q) ? hi_ab : h2_q;
        med3  = (lo_ab > lo_c) ? lo_ab : lo_c;
    end

    // Partial history publishes the newest entry
    always_comb begin
        unique case (fill_q)
            2'd3:    med_o = med3;
            2'd0:    med_o = '0;
            default: med_o = h0_q;
        endcase
    end

endmodule

// File: rtl/ultrasound_scan_scheduler.sv
// Starts the location calculator periodically or on request, watches for a
// hung calculator, median-filters distance and publishes {angle, distance}.
// Ports: clock, reset (sync, active-high), bus (slave side of the bundle).
module ultrasound_scan_scheduler
    import rover_pkg::*;
#(
    parameter int PERIOD_CYCLES     = CLK_HZ / 10,
    parameter int TIMEOUT_CYCLES    = 3 * CLK_HZ,
    parameter int CALC_RESET_CYCLES = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    ultrasound_scan_scheduler_if.slave  bus
);

    localparam int PW = $clog2(PERIOD_CYCLES);
    localparam int WW = $clog2(TIMEOUT_CYCLES);
    localparam int RW = $clog2(CALC_RESET_CYCLES + 1);

    state_t           state_q, state_d;
    logic [PW-1:0]    per_q, per_d;
    logic [WW-1:0]    wd_q, wd_d;
    logic [RW-1:0]    rc_q, rc_d;
    logic             pending_q, pending_d;
    logic             done_prev_q;
    logic [LOC_W-1:0] cap_q, cap_d;
    logic             calculate_q, calculate_d;
    logic [LOC_W-1:0] loc_q, loc_d;
    logic             valid_q, valid_d;
    logic             no_echo_q, no_echo_d;
    logic [7:0]       tcount_q, tcount_d;

    logic              wrap;
    logic              done_rise;
    logic              push;
    logic [DIST_W-1:0] med;

    assign wrap      = bus.enable && (per_q == PW'(PERIOD_CYCLES - 1));
    assign done_rise = bus.calc_done && !done_prev_q;

    median3_filter u_med (
        .clock   (clock),
        .clear_i (reset),
        .push_i  (push),
        .din_i   (cap_q[DIST_W-1:0]),
        .med_o   (med)
    );

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        wd_d        = wd_q;
        rc_d        = rc_q;
        cap_d       = cap_q;
        calculate_d = 1'b0;
        loc_d       = loc_q;
        valid_d     = 1'b0;
        no_echo_d   = no_echo_q;
        tcount_d    = tcount_q;
        push        = 1'b0;

        if (!bus.enable || wrap)
            per_d = '0;
        else
            per_d = per_q + PW'(1);

        unique case (state_q)
            S_IDLE: begin
                if (pending_q)
                    state_d = S_START;
            end
            S_START: begin
                calculate_d = 1'b1;
                pending_d   = 1'b0;
                wd_d        = '0;
                state_d     = S_WAIT;
            end
            S_WAIT: begin
                if (done_rise) begin
                    cap_d   = bus.calc_location;
                    state_d = S_FILTER;
                end else if (wd_q == WW'(TIMEOUT_CYCLES - 1)) begin
                    rc_d    = '0;
                    state_d = S_RECOVER;
                    if (tcount_q != 8'hFF)
                        tcount_d = tcount_q + 8'd1;
                end else begin
                    wd_d = wd_q + WW'(1);
                end
            end
            S_FILTER: begin
                if (is_no_echo(cap_q[DIST_W-1:0])) begin
                    no_echo_d = 1'b1;
                end else begin
                    no_echo_d = 1'b0;
                    push      = 1'b1;
                end
                state_d = S_PUBLISH;
            end
            S_PUBLISH: begin
                loc_d   = {cap_q[LOC_W-1:DIST_W], med};
                valid_d = 1'b1;
                state_d = S_IDLE;
            end
            S_RECOVER: begin
                if (rc_q == RW'(CALC_RESET_CYCLES - 1))
                    state_d = S_IDLE;
                else
                    rc_d = rc_q + RW'(1);
            end
            default: state_d = S_IDLE;
        endcase

        // A trigger landing in START re-arms rather than being lost
        if (bus.request || wrap)
            pending_d = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            per_q       <= '0;
            wd_q        <= '0;
            rc_q        <= '0;
            pending_q   <= 1'b0;
            done_prev_q <= 1'b0;
            cap_q       <= '0;
            calculate_q <= 1'b0;
            loc_q       <= '0;
            valid_q     <= 1'b0;
            no_echo_q   <= 1'b0;
            tcount_q    <= '0;
        end else begin
            state_q     <= state_d;
            per_q       <= per_d;
            wd_q        <= wd_d;
            rc_q        <= rc_d;
            pending_q   <= pending_d;
            done_prev_q <= bus.calc_done;
            cap_q       <= cap_d;
            calculate_q <= calculate_d;
            loc_q       <= loc_d;
            valid_q     <= valid_d;
            no_echo_q   <= no_echo_d;
            tcount_q    <= tcount_d;
        end
    end

    // calc_reset follows the state so it drops on the same edge as reset
    assign bus.calculate      = calculate_q;
    assign bus.calc_reset     = (state_q == S_RECOVER);
    assign bus.location       = loc_q;
    assign bus.location_valid = valid_q;
    assign bus.no_echo        = no_echo_q;
    assign bus.timeout_count  = tcount_q;
    assign bus.state          = state_q;
    assign bus.busy           = (state_q == S_WAIT)    ||
                                (state_q == S_FILTER)  ||
                                (state_q == S_PUBLISH) ||
                                (state_q == S_RECOVER) ||
                                valid_q;

endmodule

// File: tb/tb_ultrasound_scan_scheduler.sv
// Directed bench for ultrasound_scan_scheduler with a calculator model
// and a scoreboard of expected published locations.
module tb_ultrasound_scan_scheduler;
    import rover_pkg::*;

    localparam int PER = 100;
    localparam int TMO = 500;
    localparam int CRC = 4;
    localparam int LAT = 20;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    ultrasound_scan_scheduler_if bus ();

    ultrasound_scan_scheduler #(
        .PERIOD_CYCLES     (PER),
        .TIMEOUT_CYCLES    (TMO),
        .CALC_RESET_CYCLES (CRC)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [11:0] loc;
        logic        ne;
        int          rise;
    } exp_t;

    exp_t        exp_q[$];
    logic [11:0] resp_q[$];
    logic [7:0]  hist[$];
    int          calc_cyc[$];

    int   nvec = 0;
    int   nfail = 0;
    int   cyc = 0;
    int   calc_cnt = 0;
    int   valid_cnt = 0;
    int   valid_cyc = 0;
    int   cr_pulses = 0;
    int   cr_rise = 0;
    int   cr_width = 0;
    int   cr_run = 0;
    bit   cr_prev = 1'b0;
    bit   respond = 1'b1;
    int   cnt = 0;
    exp_t e_m;
    logic [11:0] v_m;
    logic        ne_m;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_dist();
        logic [7:0] a, b, c, t;
        if (hist.size() == 0) return 8'h00;
        if (hist.size() < 3) return hist[0];
        a = hist[0];
        b = hist[1];
        c = hist[2];
        if (a > b) begin t = a; a = b; b = t; end
        if (b > c) begin t = b; b = c; c = t; end
        if (a > b) begin t = a; a = b; b = t; end
        return b;
    endfunction

    always @(posedge clock) cyc = cyc + 1;

    // Monitor + calculator model, both on the falling edge
    always @(negedge clock) begin
        if (reset) begin
            bus.calc_done     = 1'b0;
            bus.calc_location = '0;
            cnt               = 0;
            cr_prev           = 1'b0;
            hist.delete();
            exp_q.delete();
        end else begin
            if (bus.calculate) begin
                calc_cnt++;
                calc_cyc.push_back(cyc);
            end
            if (bus.location_valid) begin
                valid_cnt++;
                valid_cyc = cyc;
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", 32'(bus.location), 32'hFFFF_FFFF);
                end else begin
                    e_m = exp_q.pop_front();
                    chk("location", 32'(bus.location), 32'(e_m.loc));
                    chk("no_echo", 32'(bus.no_echo), 32'(e_m.ne));
                    chk("valid_latency", cyc - e_m.rise, 3);
                end
            end
            if (bus.calc_reset) begin
                if (!cr_prev) begin
                    cr_rise = cyc;
                    cr_run  = 0;
                end
                cr_run++;
            end else if (cr_prev) begin
                cr_width = cr_run;
                cr_pulses++;
            end
            cr_prev = bus.calc_reset;

            if (bus.calculate) begin
                bus.calc_done = 1'b0;
                cnt = respond ? LAT : 0;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0 && resp_q.size() > 0) begin
                    v_m = resp_q.pop_front();
                    bus.calc_done     = 1'b1;
                    bus.calc_location = v_m;
                    ne_m = (v_m[7:0] == 8'h00) || (v_m[7:0] == 8'hFF);
                    if (!ne_m) begin
                        hist.push_front(v_m[7:0]);
                        if (hist.size() > 3) void'(hist.pop_back());
                    end
                    exp_q.push_back('{{v_m[11:8], model_dist()}, ne_m, cyc});
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    task automatic pulse();
        bus.request = 1'b1;
        tick(1);
        bus.request = 1'b0;
    endtask

    task automatic wait_valid(input int target, input int budget);
        int n = 0;
        while (valid_cnt < target && n < budget) begin tick(1); n++; end
        chk("wait_valid", 32'(valid_cnt >= target), 1);
    endtask

    task automatic wait_calc(input int target, input int budget);
        int n = 0;
        while (calc_cnt < target && n < budget) begin tick(1); n++; end
        chk("wait_calc", 32'(calc_cnt >= target), 1);
    endtask

    task automatic wait_cr(input int target, input int budget);
        int n = 0;
        while (cr_pulses < target && n < budget) begin tick(1); n++; end
        chk("wait_cr", 32'(cr_pulses >= target), 1);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_state"}, 32'(bus.state), 0);
        chk({tag, "_ctl"}, 32'({bus.calculate, bus.calc_reset,
            bus.location_valid, bus.no_echo, bus.busy}), 0);
        chk({tag, "_loc"}, 32'(bus.location), 0);
        chk({tag, "_tcnt"}, 32'(bus.timeout_count), 0);
    endtask

    initial begin
        logic [11:0] samples [5];
        int c0, v0, fv, n;
        samples = '{12'h140, 12'h510, 12'h730, 12'h9FF, 12'hA20};

        reset       = 1'b1;
        bus.enable  = 1'b0;
        bus.request = 1'b0;
        tick(3);
        check_reset("rst0");
        reset = 1'b0;

        // Periodic starts
        resp_q.push_back(12'h32A);
        resp_q.push_back(12'h32A);
        bus.enable = 1'b1;
        wait_valid(2, 400);
        bus.enable = 1'b0;
        chk("period", calc_cyc[1] - calc_cyc[0], PER);

        reset = 1'b1;
        tick(1);
        check_reset("rst1");
        reset = 1'b0;

        // Median sequence with a no-echo sample
        for (int i = 0; i < 5; i++) begin
            resp_q.push_back(samples[i]);
            v0 = valid_cnt;
            pulse();
            wait_valid(v0 + 1, 100);
        end
        chk("idle_busy", 32'(bus.busy), 0);

        // Watchdog recovery
        respond = 1'b0;
        c0 = calc_cnt;
        v0 = valid_cnt;
        n  = cr_pulses;
        pulse();
        wait_calc(c0 + 1, 20);
        tick(5);
        chk("wait_state", 32'(bus.state), 32'(S_WAIT));
        chk("wait_busy", 32'(bus.busy), 1);
        wait_cr(n + 1, 700);
        chk("cr_delay", cr_rise - calc_cyc[calc_cyc.size()-1], TMO);
        chk("cr_width", cr_width, CRC);
        chk("tcount", 32'(bus.timeout_count), 1);
        chk("no_valid", valid_cnt, v0);
        chk("post_state", 32'(bus.state), 32'(S_IDLE));

        // Coalesced triggers during WAIT_DONE
        respond = 1'b1;
        resp_q.push_back(12'h655);
        resp_q.push_back(12'h766);
        c0 = calc_cnt;
        v0 = valid_cnt;
        bus.enable = 1'b1;
        tick(90);
        pulse();
        tick(4);
        pulse();
        tick(2);
        pulse();
        wait_valid(v0 + 1, 100);
        bus.enable = 1'b0;
        fv = valid_cyc;
        wait_valid(v0 + 2, 100);
        chk("retrigger", calc_cyc[calc_cyc.size()-1] - fv, 2);
        tick(250);
        chk("calc_count", calc_cnt - c0, 2);
        chk("valid_count", valid_cnt - v0, 2);

        // Reset in WAIT_DONE
        respond = 1'b0;
        c0 = calc_cnt;
        pulse();
        wait_calc(c0 + 1, 20);
        tick(5);
        reset = 1'b1;
        tick(1);
        check_reset("rst_wait");
        reset = 1'b0;
        c0 = calc_cnt;
        tick(200);
        chk("quiet_wait", calc_cnt, c0);

        // Reset in RECOVER
        pulse();
        n = 0;
        while (!bus.calc_reset && n < 700) begin tick(1); n++; end
        chk("reach_recover", 32'(bus.calc_reset), 1);
        tick(1);
        reset = 1'b1;
        tick(1);
        check_reset("rst_rec");
        reset = 1'b0;
        c0 = calc_cnt;
        tick(100);
        chk("quiet_rec", calc_cnt, c0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
